complex_accumulator: RTL
========================

# complex_accumulator

Downstream stage of the complex multiplier. Consumes the stream of signed 18-bit complex products `{re, im}` over a valid/ready interface. Accumulates them into wide signed sums over a frame of `FRAME_LEN` products, or a shorter frame closed by `flush`. Presents the frame sum on a second valid/ready interface and holds it until accepted.

## Interface

**Parameters**
- `FRAME_LEN`, default 8: products per frame; legal range 1..255.
- `ACC_W`, default 24: width of each accumulator lane; must be ≥ 18.

**Ports**
- `clk`  in  1: clock; all state on rising edge.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `res_val`  in  1: upstream product valid.
- `res_rdy`  out  1: block accepts a product; registered.
- `res_data`  in  36: `{re[17:0], im[17:0]}`, two's complement.
- `flush`  in  1: close the current frame early; level-sampled.
- `acc_val`  out  1: frame sum valid; registered.
- `acc_rdy`  in  1: downstream accepts the sum.
- `acc_data`  out  2*ACC_W: `{re_sum, im_sum}`, two's complement.
- `acc_cnt`  out  8: number of products in the frame.

## Operation

- **Accept condition.** A product is accepted on an edge where `res_val & res_rdy`.
- **States.** Two states, ACC and OUT. Reset state is ACC.
  - In ACC, an accepted product is sign-extended from 18 to ACC_W bits. It is added to `re_sum` / `im_sum`, and `acc_cnt` increments.
  - **ACC→OUT** on an edge where either:
    - an accepted product makes `acc_cnt` reach FRAME_LEN; or
    - `flush` = 1 and the count including any product accepted that same edge is ≥ 1.
  - `flush` with count 0 and no accept is ignored; state stays ACC.
  - **OUT→ACC** on an edge where `acc_val & acc_rdy`. That edge clears `re_sum`, `im_sum` and `acc_cnt` to 0.
  - `flush` is ignored in OUT.
- **Arithmetic.** Additions wrap modulo 2^ACC_W. There is no saturation and no overflow flag.
- **Output registers.**
  - `acc_data` = `{re_sum, im_sum}` and `acc_cnt` always show the registered running values.
  - Both are stable whenever `acc_val` = 1.
- **Reset values.** While `rst_n` = 0, all outputs are 0: `res_rdy`, `acc_val`, `acc_data`, `acc_cnt`. State = ACC.
- **Reset mid-operation.** Asserting `rst_n` mid-frame, or while in OUT, discards the partial or pending sum immediately. No output handshake occurs.

## Timing

- **`res_rdy` register.** Next value = (next state == ACC).
  - First rising edge after reset release sets `res_rdy` = 1.
  - `res_rdy` falls on the same edge that enters OUT.
  - `res_rdy` rises on the same edge that completes the output handshake.
- **`acc_val` register.** Next value = (next state == OUT).
- **Latency.** Last product accepted on edge t → `acc_val` = 1 and final `acc_data` visible after edge t. That is one cycle latency.
- **Back-to-back input.** Accepts one product per cycle with no bubbles inside a frame.
- **Frame turnaround bubble.**
  - At least one cycle with `res_rdy` = 0 between frames.
  - With `acc_rdy` tied high, exactly one: first product of the next frame can be accepted on edge t+2.
- **Backpressure.** While in OUT with `acc_rdy` = 0:
  - `acc_val`, `acc_data` and `acc_cnt` are held unchanged;
  - `res_rdy` stays 0 regardless of `res_val`.
- **Simultaneous events.**
  - Accept plus `flush` on the same edge: the product is included in the frame being closed.
  - Accept that reaches FRAME_LEN plus `flush` on the same edge: treated as a normal full frame.
- **Upstream data.** `res_data` is ignored when `res_val` = 0; X on it then must not propagate.

## Test plan

- **Full frame.** FRAME_LEN=4, ACC_W=24. Accept products (1,2), (3,−4), (−5,6), (7,8) on consecutive cycles, `acc_rdy`=1.
  - Response: one cycle after the 4th accept, `acc_val`=1, `acc_data`=(6,12), `acc_cnt`=4.
  - Next cycle: `res_rdy`=1 and sums cleared.
- **Backpressure.** Same frame with `acc_rdy`=0 for 5 cycles after `acc_val` rises, `res_val` held at 1.
  - Response: `acc_val`, `acc_data`=(6,12) and `acc_cnt`=4 constant; `res_rdy`=0; no product accepted.
  - Handshake completes on the first `acc_rdy`=1 edge.
- **Early flush.** FRAME_LEN=8. Accept (100,−100), then (−1,1) with `flush`=1 on the same edge.
  - Response: `acc_data`=(99,−99), `acc_cnt`=2.
  - `flush` pulsed in ACC with count 0: no state change, `acc_val` stays 0.
- **Wrap-around.** ACC_W=20, FRAME_LEN=8. Eight products (131071, −131072).
  - Response: `re_sum` = 1048568 mod 2^20 → −8; `im_sum` = −1048576 mod 2^20 → 0; `acc_cnt`=8.
- **Reset mid-frame.** FRAME_LEN=4. Accept 3 products, then pulse `rst_n` low asynchronously between edges.
  - Response while low: `acc_val`, `res_rdy`, `acc_data` and `acc_cnt` are 0 immediately.
  - After release, a fresh 4-product frame of (1,1) yields (4,4) with no residue from the discarded products.
- **Random soak.** Random `res_val`, `acc_rdy` and `flush` over 10k cycles against a reference model.
  - Required: every accepted product appears in exactly one frame sum; every frame sum matches the model modulo 2^ACC_W.

Source files
------------

// File: rtl/complex_accumulator.sv
// complex_accumulator
//   Sums a stream of signed 18-bit complex products {re, im} into two wide
//   wrapping accumulators over a frame of FRAME_LEN products, or fewer when
//   flush closes the frame early. The finished frame sum is held on the
//   output valid/ready interface until the downstream stage takes it.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     res_val/res_rdy     product handshake (res_rdy registered)
//     res_data[35:0]      {re[17:0], im[17:0]}, two's complement
//     flush               close the current non-empty frame
//     acc_val/acc_rdy     frame-sum handshake (acc_val registered)
//     acc_data            {re_sum, im_sum}, each ACC_W bits, wrapping
//     acc_cnt[7:0]        products in the current / presented frame

// One accumulator lane: sign-extends the incoming component and adds it.
module complex_accumulator_lane #(
  parameter int ACC_W = 24,
  parameter int IN_W  = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add_en,
  input  logic             clr,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] sum
);

  logic [ACC_W-1:0] sum_q, sum_d;

  // din is only looked at when add_en is set, so X on an idle bus never
  // reaches the register.
  always_comb begin
    sum_d = sum_q;
    if (clr)         sum_d = '0;
    else if (add_en) sum_d = sum_q + ACC_W'($signed(din));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

module complex_accumulator #(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               res_val,
  output logic               res_rdy,
  input  logic [35:0]        res_data,
  input  logic               flush,
  output logic               acc_val,
  input  logic               acc_rdy,
  output logic [2*ACC_W-1:0] acc_data,
  output logic [7:0]         acc_cnt
);

  localparam int         NUM_LANES = 2;   // lane 1 = re, lane 0 = im
  localparam int         IN_W      = 18;
  localparam logic [7:0] FL8       = 8'(FRAME_LEN);

  typedef enum logic {ST_ACC, ST_OUT} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       res_rdy_q, res_rdy_d;
  logic       acc_val_q, acc_val_d;

  logic       accept, hs;
  logic [7:0] cnt_inc;
  logic [NUM_LANES-1:0][ACC_W-1:0] sum;

  // res_rdy_q is only ever high in ST_ACC, so accept implies ST_ACC.
  assign accept  = res_val & res_rdy_q;
  assign hs      = acc_val_q & acc_rdy;
  assign cnt_inc = cnt_q + {7'd0, accept};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACC: begin
        cnt_d = cnt_inc;
        // The count seen by flush includes a product accepted on this edge.
        if ((accept && cnt_inc == FL8) || (flush && cnt_inc != 8'd0))
          state_d = ST_OUT;
      end
      ST_OUT: begin
        if (hs) begin
          state_d = ST_ACC;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = ST_ACC;
    endcase
    res_rdy_d = (state_d == ST_ACC);
    acc_val_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      cnt_q     <= 8'd0;
      res_rdy_q <= 1'b0;
      acc_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_rdy_q <= res_rdy_d;
      acc_val_q <= acc_val_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    complex_accumulator_lane #(.ACC_W(ACC_W), .IN_W(IN_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .add_en (accept),
      .clr    (hs),
      .din    (res_data[g*IN_W +: IN_W]),
      .sum    (sum[g])
    );
  end

  assign res_rdy  = res_rdy_q;
  assign acc_val  = acc_val_q;
  assign acc_data = sum;
  assign acc_cnt  = cnt_q;

endmodule
